// File: rtl/mem_access_stage.sv
// MEM pipeline stage with MEM/WB register. Loads and stores run over a
// req/ack data-memory bus of variable latency while upstream stages stall.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc4_i,
  input  logic [1:0]  rf_sel_i,
  input  logic        rf_we_i,
  input  logic        dram_we_i,
  input  logic [31:0] alu_c_i,
  input  logic [31:0] rD2_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  wR_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  input  logic        err_clr_i,
  output logic [1:0]  err_o,
  output logic        rf_we_o,
  output logic [4:0]  wR_o,
  output logic [31:0] wD_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, state_nx;
  logic          memop, aligned, timeout_hit, stall, wb_load;
  logic [CW-1:0] cnt;
  logic [31:0]   ldata, sel_val;
  logic [1:0]    err_set;

  // Decode the operation and the write-back source for the current instruction
  always_comb begin
    memop       = dram_we_i | (rf_we_i & (rf_sel_i == 2'b01));
    aligned     = (alu_c_i[1:0] == 2'b00);
    timeout_hit = (TIMEOUT != 0) && (state == REQ) && !dmem_ack_i && (cnt == LAST);
    unique case (rf_sel_i)
      2'b00:   sel_val = alu_c_i;
      2'b01:   sel_val = ldata;
      2'b10:   sel_val = pc4_i;
      default: sel_val = imm_i;
    endcase
  end

  // Next-state, stall and error-set decode
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    wb_load  = 1'b0;
    err_set  = 2'b00;
    case (state)
      IDLE: begin
        if (memop) begin
          stall    = 1'b1;
          state_nx = aligned ? REQ : RESP;
          err_set  = {~aligned, 1'b0};
        end else begin
          wb_load = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ack_i || timeout_hit) state_nx = RESP;
        err_set = {1'b0, timeout_hit};
      end
      RESP: begin
        wb_load  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stall is combinational; forced low while reset is held so upstream is never frozen by a stale decode
  assign stall_o = stall & rst_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  // Bus request registers: launched from IDLE, held through REQ, dropped on ack or timeout
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else if (state == IDLE && memop && aligned) begin
      dmem_req_o   <= 1'b1;
      dmem_we_o    <= dram_we_i;
      dmem_addr_o  <= alu_c_i;
      dmem_wdata_o <= rD2_i;
    end else if (state == REQ && (dmem_ack_i || timeout_hit)) begin
      dmem_req_o <= 1'b0;
      dmem_we_o  <= 1'b0;
    end
  end

  // Counts REQ cycles without ack; restarts every time the FSM is idle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                  cnt <= '0;
    else if (state == IDLE)                      cnt <= '0;
    else if (state == REQ && !dmem_ack_i && !timeout_hit) cnt <= cnt + CW'(1);
  end

  // Load-data latch: read data on ack, zero on any aborted access
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                  ldata <= '0;
    else if (state == IDLE && memop && !aligned) ldata <= '0;
    else if (state == REQ && dmem_ack_i)         ldata <= dmem_rdata_i;
    else if (timeout_hit)                        ldata <= '0;
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_o <= '0;
    else        err_o <= (err_clr_i ? 2'b00 : err_o) | err_set;
  end

  // MEM/WB register: loads on non-memop IDLE and on RESP, bubble otherwise
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rf_we_o <= 1'b0;
      wR_o    <= '0;
      wD_o    <= '0;
    end else if (wb_load) begin
      rf_we_o <= rf_we_i;
      wR_o    <= wR_i;
      wD_o    <= sel_val;
    end else begin
      rf_we_o <= 1'b0;
      wR_o    <= '0;
      wD_o    <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: per-instruction transaction model
// predicting stall length, bus activity, write-back values and error flags.
module tb_mem_access_stage;

  localparam int unsigned TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc4_i, alu_c_i, rD2_i, imm_i, dmem_rdata_i;
  logic [1:0]  rf_sel_i;
  logic        rf_we_i, dram_we_i, dmem_ack_i, err_clr_i;
  logic [4:0]  wR_i;
  logic        dmem_req_o, dmem_we_o, stall_o, rf_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wD_o;
  logic [1:0]  err_o;
  logic [4:0]  wR_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_ld;
  logic [1:0]  m_err;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc4_i(pc4_i), .rf_sel_i(rf_sel_i),
    .rf_we_i(rf_we_i), .dram_we_i(dram_we_i), .alu_c_i(alu_c_i), .rD2_i(rD2_i),
    .imm_i(imm_i), .wR_i(wR_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .stall_o(stall_o),
    .err_clr_i(err_clr_i), .err_o(err_o), .rf_we_o(rf_we_o), .wR_o(wR_o), .wD_o(wD_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive_nop();
    rf_sel_i = 2'b00; rf_we_i = 1'b0; dram_we_i = 1'b0;
    alu_c_i = '0; rD2_i = '0; imm_i = '0; pc4_i = '0; wR_i = '0;
  endtask

  // One instruction from EX/MEM. lat = REQ cycle in which ack is given (1 = first);
  // values outside 1..TO mean the ack never arrives.
  task automatic run_instr(input logic [1:0] sel, input logic we, input logic dwe,
                           input logic [31:0] alu, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [31:0] pc4,
                           input logic [4:0] wr, input int lat,
                           input logic [31:0] rdata, input logic clr, input string tag);
    logic        memop;
    int          exp_stall, exp_req, stall_n, req_n;
    logic [31:0] new_ld, exp_wd;
    logic [1:0]  set, exp_err;
    bit          done;
    memop = dwe | (we && sel == 2'b01);
    if (!memop) begin
      exp_stall = 0; exp_req = 0; new_ld = m_ld; set = 2'b00;
    end else if (alu[1:0] != 2'b00) begin
      exp_stall = 1; exp_req = 0; new_ld = '0; set = 2'b10;
    end else if (lat >= 1 && lat <= int'(TO)) begin
      exp_stall = 1 + lat; exp_req = lat; new_ld = rdata; set = 2'b00;
    end else begin
      exp_stall = 1 + int'(TO); exp_req = int'(TO); new_ld = '0; set = 2'b01;
    end
    exp_err = (clr ? 2'b00 : m_err) | set;
    case (sel)
      2'b00:   exp_wd = alu;
      2'b01:   exp_wd = new_ld;
      2'b10:   exp_wd = pc4;
      default: exp_wd = imm;
    endcase

    rf_sel_i = sel; rf_we_i = we; dram_we_i = dwe; alu_c_i = alu; rD2_i = rd2;
    imm_i = imm; pc4_i = pc4; wR_i = wr; err_clr_i = clr;
    stall_n = 0; req_n = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk_i);
      if (i > 0) err_clr_i = 1'b0;
      if (dmem_req_o) begin
        req_n++;
        checks++;
        if ({dmem_we_o, dmem_addr_o, dmem_wdata_o} !== {dwe, alu, rd2}) begin
          errors++;
          $display("FAIL %s bus: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                   tag, dmem_we_o, dmem_addr_o, dmem_wdata_o, dwe, alu, rd2);
        end
        dmem_ack_i   = (req_n == lat);
        dmem_rdata_i = dmem_ack_i ? rdata : $urandom;
      end else begin
        dmem_ack_i   = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
      end
      if (stall_o) begin
        stall_n++;
        if (i > 0) begin
          checks++;
          if ({rf_we_o, wR_o, wD_o} !== 38'd0) begin
            errors++;
            $display("FAIL %s bubble: got we=%0b wR=%0d wD=%h want all zero", tag, rf_we_o, wR_o, wD_o);
          end
        end
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s stall_release: stall still high after 60 cycles, want release", tag);
    end
    @(posedge clk_i);
    #1;
    dmem_ack_i = 1'b0;
    err_clr_i  = 1'b0;
    checks++;
    if (stall_n != exp_stall) begin
      errors++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_n, exp_stall);
    end
    checks++;
    if (req_n != exp_req) begin
      errors++; $display("FAIL %s req_cycles: got %0d want %0d", tag, req_n, exp_req);
    end
    checks++;
    if ({rf_we_o, wR_o, wD_o} !== {we, wr, exp_wd}) begin
      errors++;
      $display("FAIL %s wb: got we=%0b wR=%0d wD=%h want we=%0b wR=%0d wD=%h",
               tag, rf_we_o, wR_o, wD_o, we, wr, exp_wd);
    end
    checks++;
    if (err_o !== exp_err) begin
      errors++; $display("FAIL %s err: got %b want %b", tag, err_o, exp_err);
    end
    m_ld  = new_ld;
    m_err = exp_err;
    drive_nop();
  endtask

  task automatic test_reset();
    rst_i = 1'b0; err_clr_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    drive_nop();
    rf_sel_i = 2'b01; rf_we_i = 1'b1; alu_c_i = 32'h40;  // pending load must not stall in reset
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o, err_o, rf_we_o, wR_o, wD_o} !== '0) begin
      errors++;
      $display("FAIL reset: got req=%0b we=%0b addr=%h stall=%0b err=%b rf_we=%0b wR=%0d wD=%h want all zero",
               dmem_req_o, dmem_we_o, dmem_addr_o, stall_o, err_o, rf_we_o, wR_o, wD_o);
    end
    drive_nop();
    @(negedge clk_i);
    rst_i = 1'b1;
    m_ld = '0; m_err = '0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_alu();
    run_instr(2'b00, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h4, 5'd3, 0, 32'h0, 1'b0, "alu");
    run_instr(2'b10, 1'b1, 1'b0, 32'h77, 32'h0, 32'h0, 32'h1004, 5'd7, 0, 32'h0, 1'b0, "pc4");
    run_instr(2'b11, 1'b1, 1'b0, 32'h77, 32'h0, 32'hABCD, 32'h8, 5'd9, 0, 32'h0, 1'b0, "imm");
  endtask

  task automatic test_load();
    run_instr(2'b01, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd5, 2, 32'hDEADBEEF, 1'b0, "load");
  endtask

  task automatic test_store();
    run_instr(2'b00, 1'b0, 1'b1, 32'h200, 32'h1234, 32'h0, 32'h0, 5'd0, 1, 32'h5555, 1'b0, "store");
  endtask

  task automatic test_misaligned();
    run_instr(2'b01, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 32'h0, 5'd6, 1, 32'h0, 1'b0, "misaligned");
    run_instr(2'b00, 1'b0, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b1, "clr_misaligned");
  endtask

  task automatic test_timeout();
    run_instr(2'b01, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 5'd8, -1, 32'h0, 1'b0, "timeout");
    run_instr(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b1, "err_clr");
    run_instr(2'b01, 1'b1, 1'b0, 32'h304, 32'h0, 32'h0, 32'h0, 5'd9, int'(TO), 32'hCAFEF00D, 1'b0, "ack_last");
    run_instr(2'b01, 1'b1, 1'b0, 32'h308, 32'h0, 32'h0, 32'h0, 5'd10, -1, 32'h0, 1'b0, "timeout2");
    run_instr(2'b01, 1'b1, 1'b0, 32'h30A, 32'h0, 32'h0, 32'h0, 5'd11, 1, 32'h0, 1'b1, "set_wins");
    run_instr(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b1, "err_clr2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] alu;
      int lat;
      alu = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
      lat = ($urandom_range(0, 9) == 0) ? int'(TO) + 1 : int'($urandom_range(1, 4));
      run_instr(2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), alu, $urandom,
                $urandom, $urandom, 5'($urandom), lat, $urandom,
                ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  task automatic test_reset_mid_req();
    int seen;
    rf_sel_i = 2'b01; rf_we_i = 1'b1; dram_we_i = 1'b0; alu_c_i = 32'h400; wR_i = 5'd12;
    dmem_ack_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen < 2; i++) begin
      @(negedge clk_i);
      if (dmem_req_o) seen++;
    end
    checks++;
    if (seen != 2) begin
      errors++; $display("FAIL mid_req_setup: req cycles seen %0d want 2", seen);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, stall_o, rf_we_o, err_o} !== 5'b0) begin
      errors++;
      $display("FAIL mid_req_reset: got req=%0b stall=%0b rf_we=%0b err=%b want all zero",
               dmem_req_o, stall_o, rf_we_o, err_o);
    end
    drive_nop();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    rst_i = 1'b1;
    m_ld = '0; m_err = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({dmem_req_o, stall_o, rf_we_o, err_o} !== 5'b0) begin
        errors++;
        $display("FAIL late_ack: got req=%0b stall=%0b rf_we=%0b err=%b want all zero",
                 dmem_req_o, stall_o, rf_we_o, err_o);
      end
    end
    dmem_ack_i = 1'b0;
    // latch must still be zero: a DRAM-sourced non-memop write-back exposes it
    run_instr(2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd2, 0, 32'h0, 1'b0, "ld_after_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
